// File: rtl/ifq_pkg.sv
// ifq_pkg: shared entry type, PC step and counter-width helper for the instruction-fetch queue
package ifq_pkg;
    localparam logic [31:0] PC_STEP = 32'd4;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;
    function automatic int ifq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry circular FIFO of {pc, inst} entries with flush
// Ports: clk, reset_b (async active-low); i_push/i_entry write the tail,
// i_pop retires the head, i_flush empties the queue (wins over push/pop);
// o_head/o_valid present the head entry (zero when empty), o_count is occupancy.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = ifq_cnt_w(DEPTH),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            i_push,
    input  ifq_entry_t      i_entry,
    input  logic            i_pop,
    input  logic            i_flush,
    output ifq_entry_t      o_head,
    output logic            o_valid,
    output logic [CW-1:0]   o_count
);
    ifq_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PW'(1);
            if (i_pop) r_rd <= r_rd + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_entry;
    end
    assign o_valid = r_count != '0;
    // head is forced to zero when empty so stale storage never reaches the core
    assign o_head  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_count;
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_b)
        !(i_push && !i_pop && !i_flush && r_count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_b)
        !(i_pop && r_count == '0));
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with credit-limited requests, in-order responses and redirect flush
// Ports: clk, reset_b (async active-low); redirect_valid/redirect_pc restart fetch;
// mem_req_valid/mem_req_addr/mem_req_ready form the request channel;
// mem_rsp_valid/mem_rsp_data return words in request order (never back-pressured);
// inst_valid/inst/inst_pc/inst_ready deliver buffered instructions to the core.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int IMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       mem_req_valid,
    output logic [IMEM_ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                       mem_req_ready,
    input  logic                       mem_rsp_valid,
    input  logic [31:0]                mem_rsp_data,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    input  logic                       inst_ready
);
    localparam int CW = ifq_cnt_w(DEPTH);
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_live;
    logic [31:0]   w_target;
    logic          w_accept;
    logic          w_keep;
    logic          w_pop;
    logic          w_unused;
    ifq_entry_t    w_head;
    ifq_entry_t    w_push_entry;
    assign w_target = {redirect_pc[31:2], 2'b00};
    assign w_unused = &{1'b0, redirect_pc[1:0]};
    // buffered + in-flight never exceeds DEPTH, so every kept response has a free slot
    assign mem_req_valid = !redirect_valid && (({1'b0, w_count} + {1'b0, r_outstanding}) < LIMIT);
    assign mem_req_addr  = r_fetch_pc[IMEM_ADDR_WIDTH-1:0];
    assign w_accept      = mem_req_valid && mem_req_ready;
    assign w_keep        = mem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_pop         = inst_valid && inst_ready;
    // responses still in flight after a redirect are stale and must be dropped
    assign w_live        = r_outstanding - CW'(mem_rsp_valid);
    assign w_push_entry  = '{pc: r_rsp_pc, inst: mem_rsp_data};
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_fetch_pc    <= '0;
            r_rsp_pc      <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= w_target;
            r_rsp_pc      <= w_target;
            r_outstanding <= w_live;
            r_drop        <= w_live;
        end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_keep) r_rsp_pc <= r_rsp_pc + PC_STEP;
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(mem_rsp_valid);
            if (mem_rsp_valid && r_drop != '0) r_drop <= r_drop - CW'(1);
        end
    end
    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .i_push  (w_keep),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_valid (inst_valid),
        .o_count (w_count)
    );
    assign inst    = w_head.inst;
    assign inst_pc = w_head.pc;
endmodule
